// File: rtl/reg_mem.sv
// rtl/reg_mem.sv - flop-based register-file memory with shared address and registered read port
module reg_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wen,
  input  logic                  clk,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  rst_n
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Array and read register: async clear, then write-through on write or registered read otherwise.
  // An unknown wen fails the equality test and falls to the read branch, so it never writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      data_out <= '0;
    end else if (wen == 1'b1) begin
      mem[addr] <= data_in;
      data_out  <= data_in;
    end else begin
      data_out <= mem[addr];
    end
  end

endmodule

// File: tb/tb_reg_mem.sv
// tb/tb_reg_mem.sv - directed self-checking bench for reg_mem
module tb_reg_mem;

  logic [4:0] addr;
  logic [7:0] data_in;
  logic       wen;
  logic       clk;
  logic [7:0] data_out;
  logic       rst_n;
  logic       clk_en;

  int n_cmp;
  int n_fail;

  reg_mem #(8, 5) dut (
    .addr     (addr),
    .data_in  (data_in),
    .wen      (wen),
    .clk      (clk),
    .data_out (data_out),
    .rst_n    (rst_n)
  );

  // Gated clock so reset can be checked with no edges at all.
  always #5 clk = clk_en ? ~clk : clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    addr = a; data_in = d; wen = 1'b1;
    step();
  endtask

  task automatic do_read(input logic [4:0] a);
    addr = a; data_in = 8'h00; wen = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_no_clock: data_out=%h expected=%h", data_out, 8'h00);
    end
    #2;
    rst_n = 1'b1;
    clk_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      do_read(5'(i));
      n_cmp++;
      if (data_out !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_read[%0d]: data_out=%h expected=%h", i, data_out, 8'h00);
      end
    end
  endtask

  task automatic test_fill_readback();
    for (int i = 0; i < 32; i++) begin
      do_write(5'(i), 8'(i));
      n_cmp++;
      if (data_out !== 8'(i)) begin
        n_fail++;
        $display("FAIL fill_through[%0d]: data_out=%h expected=%h", i, data_out, 8'(i));
      end
    end
    for (int i = 0; i < 32; i++) begin
      do_read(5'(i));
      n_cmp++;
      if (data_out !== 8'(i)) begin
        n_fail++;
        $display("FAIL readback[%0d]: data_out=%h expected=%h", i, data_out, 8'(i));
      end
    end
  endtask

  task automatic test_write_through();
    do_write(5'd7, 8'hA5);
    n_cmp++;
    if (data_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL write_through: data_out=%h expected=%h", data_out, 8'hA5);
    end
    do_read(5'd7);
    n_cmp++;
    if (data_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL write_through_read: data_out=%h expected=%h", data_out, 8'hA5);
    end
  endtask

  task automatic test_overwrite_isolation();
    do_write(5'd31, 8'h3C);
    do_write(5'd0, 8'hFF);
    do_read(5'd31);
    n_cmp++;
    if (data_out !== 8'h3C) begin
      n_fail++;
      $display("FAIL iso_read31: data_out=%h expected=%h", data_out, 8'h3C);
    end
    do_read(5'd1);
    n_cmp++;
    if (data_out !== 8'h01) begin
      n_fail++;
      $display("FAIL iso_read1: data_out=%h expected=%h", data_out, 8'h01);
    end
    do_read(5'd0);
    n_cmp++;
    if (data_out !== 8'hFF) begin
      n_fail++;
      $display("FAIL iso_read0: data_out=%h expected=%h", data_out, 8'hFF);
    end
    do_read(5'd7);
    n_cmp++;
    if (data_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL iso_read7: data_out=%h expected=%h", data_out, 8'hA5);
    end
  endtask

  task automatic test_async_reset_midrun();
    do_read(5'd30);
    n_cmp++;
    if (data_out !== 8'h1E) begin
      n_fail++;
      $display("FAIL pre_reset_read30: data_out=%h expected=%h", data_out, 8'h1E);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL midrun_reset: data_out=%h expected=%h", data_out, 8'h00);
    end
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      do_read(5'(i));
      n_cmp++;
      if (data_out !== 8'h00) begin
        n_fail++;
        $display("FAIL post_reset_read[%0d]: data_out=%h expected=%h", i, data_out, 8'h00);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h11; exp_seq[2] = 8'h22; exp_seq[3] = 8'h22;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: do_write(5'd5, 8'h11);
        1: do_read(5'd5);
        2: do_write(5'd5, 8'h22);
        default: do_read(5'd5);
      endcase
      n_cmp++;
      if (data_out !== exp_seq[k]) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: data_out=%h expected=%h", k, data_out, exp_seq[k]);
      end
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    clk     = 1'b0;
    clk_en  = 1'b0;
    addr    = '0;
    data_in = '0;
    wen     = 1'b0;
    rst_n   = 1'b1;
    test_reset();
    test_fill_readback();
    test_write_through();
    test_overwrite_isolation();
    test_async_reset_midrun();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
